// File: rtl/uart_rx_deframer.sv
// Oversampled UART receiver: 2-FF synchronizer, mid-bit sampling FSM, valid/ready byte out.
// Result registered one cycle after the stop sample; a byte arriving while valid_o is held is dropped (overrun_o).
module uart_rx_deframer #(
  parameter int unsigned CLK_DIV   = 104,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam int unsigned   IW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rxs;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  assign rxs = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Handshake is resolved first so a same-cycle frame completion sees the slot as free.
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxs) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = FULL_M1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_M1;
          if (idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxs) begin
          state_d = IDLE;
          if (!valid_d) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule
